// File: rtl/qarctan_pkg.sv
// Shared constants and state encoding for the quadrature-arctangent sequencer.
package qarctan_pkg;

  localparam int BITS_DEF = 10;
  localparam int QUAD1    = 804;
  localparam int QUAD3    = 2412;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    SCALE = 3'd4,
    OUT   = 3'd5
  } state_t;

endpackage

// File: rtl/qarctan_div_ctrl_if.sv
// Sample input, divider request/response and angle output channels of the
// arctangent sequencer. The master side is the sequencer itself.
interface qarctan_div_ctrl_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_x;
  logic [DATA_WIDTH-1:0] in_y;

  logic                  div_valid_in;
  logic [63:0]           div_dividend;
  logic [31:0]           div_divisor;
  logic                  div_valid_out;
  logic [63:0]           div_quotient;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_angle;

  modport master (
    input  in_valid, in_x, in_y, div_valid_out, div_quotient, out_ready,
    output in_ready, div_valid_in, div_dividend, div_divisor, out_valid, out_angle
  );

  modport slave (
    output in_valid, in_x, in_y, div_valid_out, div_quotient, out_ready,
    input  in_ready, div_valid_in, div_dividend, div_divisor, out_valid, out_angle
  );

endinterface

// File: rtl/qarctan_scale.sv
// Turns the divider quotient into a signed fixed-point angle:
// angle = +/-(base - trunc0(QUAD1 * r / 2^BITS)).
module qarctan_scale
  import qarctan_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = BITS_DEF
) (
  input  logic [DATA_WIDTH-1:0] i_r,
  input  logic [DATA_WIDTH-1:0] i_base,
  input  logic                  i_ysign,
  output logic [DATA_WIDTH-1:0] o_angle
);

  localparam logic signed [63:0] C_QUAD1 = 64'(QUAD1);
  localparam logic signed [63:0] C_BIAS  = (64'sd1 <<< BITS) - 64'sd1;

  logic signed [63:0] w_rExt;
  logic signed [63:0] w_baseExt;
  logic signed [63:0] w_prod;
  logic signed [63:0] w_bias;
  logic signed [63:0] w_scaled;
  logic signed [63:0] w_a;

  // Multiply, divide by 2^BITS rounding toward zero (bias negatives before the shift), then apply the y sign.
  always_comb begin
    w_rExt    = {{(64-DATA_WIDTH){i_r[DATA_WIDTH-1]}}, i_r};
    w_baseExt = {{(64-DATA_WIDTH){i_base[DATA_WIDTH-1]}}, i_base};
    w_prod    = w_rExt * C_QUAD1;
    w_bias    = w_prod[63] ? C_BIAS : 64'sd0;
    w_scaled  = (w_prod + w_bias) >>> BITS;
    w_a       = w_baseExt - w_scaled;
    o_angle   = i_ysign ? DATA_WIDTH'(-w_a) : DATA_WIDTH'(w_a);
  end

endmodule

// File: rtl/qarctan_div_ctrl.sv
// Arctangent step sequencer: accepts an I/Q sample, forms the ratio operands,
// hands them to the external long divider and scales the quotient to an angle.
module qarctan_div_ctrl
  import qarctan_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = BITS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  qarctan_div_ctrl_if.master io_bus
);

  state_t                r_state;
  state_t                w_next;

  logic [DATA_WIDTH-1:0] r_x;
  logic [DATA_WIDTH-1:0] r_y;
  logic                  r_ysign;
  logic [DATA_WIDTH-1:0] r_base;
  logic [63:0]           r_dividend;
  logic [31:0]           r_divisor;
  logic [DATA_WIDTH-1:0] r_r;
  logic [DATA_WIDTH-1:0] r_angle;

  logic [DATA_WIDTH-1:0] w_absY;
  logic [DATA_WIDTH-1:0] w_num;
  logic [DATA_WIDTH-1:0] w_den;
  logic [DATA_WIDTH-1:0] w_base;
  logic [63:0]           w_numExt;
  logic [DATA_WIDTH-1:0] w_angle;
  logic                  w_unused;

  // Only the low DATA_WIDTH bits of the quotient carry the ratio.
  assign w_unused = ^io_bus.div_quotient[63:DATA_WIDTH];

  // State register; reset returns to IDLE from anywhere.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and the state-decoded handshake outputs.
  always_comb begin
    w_next              = r_state;
    io_bus.in_ready     = 1'b0;
    io_bus.div_valid_in = 1'b0;
    io_bus.out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        io_bus.in_ready = 1'b1;
        if (io_bus.in_valid) w_next = PREP;
      end
      PREP:  w_next = ISSUE;
      ISSUE: begin
        io_bus.div_valid_in = 1'b1;
        w_next              = WAIT;
      end
      WAIT: begin
        if (io_bus.div_valid_out) w_next = SCALE;
      end
      SCALE: w_next = OUT;
      OUT: begin
        io_bus.out_valid = 1'b1;
        if (io_bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand formation: |y|+1 keeps the denominator nonzero; the quadrant base depends on the sign of x.
  always_comb begin
    w_absY = (r_y[DATA_WIDTH-1] ? -r_y : r_y) + DATA_WIDTH'(1);
    if (!r_x[DATA_WIDTH-1]) begin
      w_num  = r_x - w_absY;
      w_den  = r_x + w_absY;
      w_base = DATA_WIDTH'(QUAD1);
    end else begin
      w_num  = r_x + w_absY;
      w_den  = w_absY - r_x;
      w_base = DATA_WIDTH'(QUAD3);
    end
    w_numExt = {{(64-DATA_WIDTH){w_num[DATA_WIDTH-1]}}, w_num};
  end

  qarctan_scale #(
    .DATA_WIDTH (DATA_WIDTH),
    .BITS       (BITS)
  ) u_scale (
    .i_r     (r_r),
    .i_base  (r_base),
    .i_ysign (r_ysign),
    .o_angle (w_angle)
  );

  // Datapath registers, each loaded in the single state that owns it and held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x        <= '0;
      r_y        <= '0;
      r_ysign    <= 1'b0;
      r_base     <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_r        <= '0;
      r_angle    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (io_bus.in_valid) begin
            r_x     <= io_bus.in_x;
            r_y     <= io_bus.in_y;
            r_ysign <= io_bus.in_y[DATA_WIDTH-1];
          end
        end
        PREP: begin
          r_dividend <= w_numExt << BITS;
          r_divisor  <= 32'(w_den);
          r_base     <= w_base;
        end
        WAIT: begin
          if (io_bus.div_valid_out) r_r <= io_bus.div_quotient[DATA_WIDTH-1:0];
        end
        SCALE: r_angle <= w_angle;
        default: ;
      endcase
    end
  end

  assign io_bus.div_dividend = r_dividend;
  assign io_bus.div_divisor  = r_divisor;
  assign io_bus.out_angle    = r_angle;

endmodule

// File: doc/qarctan_div_ctrl.md
# qarctan_div_ctrl

Sequencer for the FM demodulator's quadrature-arctangent step. It accepts one I/Q sample over a valid/ready handshake and forms the ratio numerator and denominator. It issues them to the sibling long divider (64-bit dividend, 32-bit divisor), waits for the quotient, and scales the quotient into a signed fixed-point phase angle. The angle is presented downstream over valid/ready; the block feeds the divider and consumes its quotient.

## Interface
- DATA_WIDTH, 32, width of I/Q samples and of the output angle (signed)
- BITS, 10, fractional bits of the fixed-point format
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  sample valid
- in_ready  out  1  high only in IDLE
- in_x  in  DATA_WIDTH  real part (signed)
- in_y  in  DATA_WIDTH  imaginary part (signed)
- div_valid_in  out  1  one-cycle start pulse to the divider
- div_dividend  out  64  dividend; held from the pulse until the quotient is captured
- div_divisor  out  32  divisor; held as above
- div_valid_out  in  1  divider done pulse; quotient is valid in the same cycle
- div_quotient  in  64  signed quotient, truncated toward zero
- out_valid  out  1  angle valid
- out_ready  in  1  downstream accepts
- out_angle  out  DATA_WIDTH  signed angle, scaled by 2^BITS (pi ≈ 3217)

## Operation
- States and transitions:
  - IDLE: in_valid → PREP.
  - PREP → ISSUE.
  - ISSUE → WAIT.
  - WAIT: div_valid_out → SCALE.
  - SCALE → OUT.
  - OUT: out_ready → IDLE.
- IDLE: in_ready=1. On in_valid, register x, y, and ysign=y[DATA_WIDTH-1].
- PREP: compute and register the operands.
  - abs_y = |y| + 1, in DATA_WIDTH bits; |most-negative| wraps, which is accepted.
  - x ≥ 0: num = x − abs_y, den = x + abs_y, base = QUAD1.
  - x < 0: num = x + abs_y, den = abs_y − x, base = QUAD3.
  - div_dividend = sign-extend(num) to 64 bits, then shifted left by BITS.
  - div_divisor = den[31:0].
  - den ≥ 1 always, so divide-by-zero is unreachable.
- ISSUE: div_valid_in=1 for exactly this cycle.
- WAIT: operands held constant. On div_valid_out, register r = div_quotient[DATA_WIDTH-1:0] (signed). There is no timeout.
- SCALE: compute and register out_angle.
  - prod = QUAD1·r, computed at 64-bit signed width.
  - scaled = prod / 2^BITS, truncated toward zero (not an arithmetic shift).
  - a = base − scaled.
  - out_angle = ysign ? −a : a.
- OUT: out_valid=1. out_angle is stable until out_ready. The handshake completes on a cycle where out_valid & out_ready; the block then returns to IDLE.
- Constants: QUAD1 = 804 (round(π/4·2^BITS)) and QUAD3 = 2412 (3·QUAD1) at BITS=10.
- div_valid_out outside WAIT is ignored.

## Timing
- Reset values (taking effect at the first edge with reset=1):
  - state=IDLE, so in_ready=1 after reset.
  - out_valid=0, out_angle=0, div_valid_in=0, div_dividend=0, div_divisor=0.
  - Internal x, y, r registers = 0.
- Accept at edge E0. PREP is the cycle after E0; div_valid_in is high in the second cycle after E0, and the divider samples it at E2.
- Latency from div_valid_out to out_valid = 2 edges: capture → SCALE, then → OUT.
- One transaction in flight. in_ready=0 from acceptance until the cycle after the out handshake, so there is no back-to-back overlap.
- Reset mid-operation, any state: back to IDLE on the next edge and div_valid_in drops. A stale divider result arriving later is ignored because the block is in IDLE.
- Simultaneous in_valid and reset: reset wins and no sample is taken.

## Structure
- Package qarctan_pkg holds:
  - the BITS default, QUAD1, QUAD3;
  - state_t enum {IDLE, PREP, ISSUE, WAIT, SCALE, OUT}, 3 bits.
- One sub-module: qarctan_scale (combinational).
  - Inputs r, base, ysign; output angle.
  - Contains the multiply, truncation toward zero, and negation.
- The divider is not instantiated here. It is a sibling in the demodulator top.

## Test plan
- x=1024, y=0 → dividend=1047552, divisor=1025, quotient 1022 → out_angle=2.
- x=0, y=1024 → dividend=−1049600, divisor=1025, quotient −1024 → out_angle=1608.
- x=0, y=−1024 → out_angle=−1608.
- x=−1024, y=0 → divisor=1025, quotient −1022 → scaled=−802 (toward zero) → out_angle=3214.
- Back-pressure: hold out_ready=0 for 5 cycles in OUT → out_valid stays 1, out_angle unchanged, in_ready=0. Release out_ready → IDLE on the next edge.
- Reset asserted in WAIT, then div_valid_out pulses after reset deasserts → no out_valid, in_ready=1, all outputs 0. The next sample processes normally.
